// File: rtl/bcd_conv_arbiter.sv
// Two-requester binary-to-BCD conversion controller driving an external shift-add-3 datapath.
// Define BCD_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise req0 has fixed priority.
module bcd_conv_arbiter #(
  parameter int WIDTH  = 36,
  parameter int DIGITS = 11
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [WIDTH-1:0]      data0,
  input  logic [WIDTH-1:0]      data1,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  done0,
  output logic                  done1,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  dp_load,
  output logic [WIDTH-1:0]      dp_data,
  output logic                  dp_shift,
  input  logic [4*DIGITS-1:0]   dp_bcd
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              grant_q, grant_d;   // 1 selects requester 1
  logic              pick;

  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic              busy_q, busy_d;
  logic              dp_load_q, dp_load_d;
  logic              dp_shift_q, dp_shift_d;
  logic [WIDTH-1:0]  dp_data_q, dp_data_d;
  logic [4*DIGITS-1:0] bcd_out_q;

`ifdef BCD_ARB_ROUND_ROBIN_EN
  logic prio1_q;  // set when requester 1 should win the next tie

  always_ff @(posedge Clk) begin
    if (Rst) begin
      prio1_q <= 1'b0;
    end else if (state_q == LOAD) begin
      prio1_q <= ~grant_q;
    end
  end

  always_comb begin
    pick = (req0 && req1) ? prio1_q : req1;
  end
`else
  always_comb begin
    pick = ~req0;
  end
`endif

  // State and registered outputs
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      grant_q    <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      busy_q     <= 1'b0;
      dp_load_q  <= 1'b0;
      dp_shift_q <= 1'b0;
      dp_data_q  <= '0;
      bcd_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      busy_q     <= busy_d;
      dp_load_q  <= dp_load_d;
      dp_shift_q <= dp_shift_d;
      dp_data_q  <= dp_data_d;
      if (state_q == SHIFT && state_d == DONE) begin
        bcd_out_q <= dp_bcd;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = LOAD;
          grant_d = pick;
        end
      end
      LOAD: begin
        state_d = SHIFT;
        cnt_d   = CW'(WIDTH - 1);
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the registered state
  always_comb begin
    ack0_d     = (state_d == LOAD) && !grant_d;
    ack1_d     = (state_d == LOAD) &&  grant_d;
    done0_d    = (state_d == DONE) && !grant_d;
    done1_d    = (state_d == DONE) &&  grant_d;
    busy_d     = (state_d != IDLE);
    dp_load_d  = (state_d == LOAD);
    dp_shift_d = (state_d == SHIFT);
    dp_data_d  = '0;
    if (state_d == LOAD) begin
      dp_data_d = grant_d ? data1 : data0;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign busy     = busy_q;
  assign dp_load  = dp_load_q;
  assign dp_shift = dp_shift_q;
  assign dp_data  = dp_data_q;
  assign bcd_out  = bcd_out_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Randomized bench for bcd_conv_arbiter with a double-dabble datapath stub and a
// decimal-arithmetic reference model.
module tb_bcd_conv_arbiter;

  localparam int W  = 36;
  localparam int D  = 11;
  localparam int BW = 4 * D;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1;
  logic [W-1:0]  data0, data1;
  logic          ack0, ack1, done0, done1, busy;
  logic [BW-1:0] bcd_out;
  logic          dp_load, dp_shift;
  logic [W-1:0]  dp_data;
  logic [BW-1:0] dp_bcd;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  bcd_conv_arbiter #(.WIDTH(W), .DIGITS(D)) dut (
    .Clk(clk), .Rst(rst),
    .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .busy(busy), .bcd_out(bcd_out),
    .dp_load(dp_load), .dp_data(dp_data), .dp_shift(dp_shift), .dp_bcd(dp_bcd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stub: shift-add-3 converter; dp_bcd shows the value after the current shift
  logic [W-1:0]  sr;
  logic [BW-1:0] acc;

  function automatic logic [BW-1:0] dabble(input logic [BW-1:0] a, input logic b);
    logic [BW-1:0] t;
    t = a;
    for (int i = 0; i < D; i++) begin
      if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
    end
    return {t[BW-2:0], b};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      acc <= '0;
    end else if (dp_load) begin
      sr  <= dp_data;
      acc <= '0;
    end else if (dp_shift) begin
      acc <= dabble(acc, sr[W-1]);
      sr  <= sr << 1;
    end
  end

  assign dp_bcd = dp_shift ? dabble(acc, sr[W-1]) : acc;

  // Reference: decimal digits by repeated division
  function automatic logic [BW-1:0] ref_bcd(input logic [W-1:0] v);
    longint unsigned x;
    logic [BW-1:0] r;
    x = 64'(v);
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rnd36();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One conversion for requester 'who'; optionally raises the other request mid-SHIFT
  task automatic conv(input int who, input logic [W-1:0] val, input bit raise_other,
                      input logic [W-1:0] oval);
    int n, ns, nd;
    bit stray, dpnz, raised;
    n = 0; ns = 0; nd = 0; stray = 0; dpnz = 0; raised = 0;
    if (who == 0) begin req0 = 1'b1; data0 = val; end
    else          begin req1 = 1'b1; data1 = val; end
    while (!(who == 0 ? ack0 : ack1) && n < 8) begin
      tick();
      n++;
    end
    chk("ack_latency", n, 1);
    chk("ack_other", who == 0 ? ack1 : ack0, 0);
    chk("dp_load", dp_load, 1);
    chk("dp_data_load", dp_data, val);
    if (who == 0) begin req0 = 1'b0; data0 = rnd36(); end
    else          begin req1 = 1'b0; data1 = rnd36(); end
    while (!(done0 || done1) && nd < W + 10) begin
      tick();
      nd++;
      ns += int'(dp_shift);
      if (dp_data != '0) dpnz = 1'b1;
      if (who == 0 ? ack1 : ack0) stray = 1'b1;
      if (raise_other && !raised && ns == 5) begin
        if (who == 0) begin req1 = 1'b1; data1 = oval; end
        else          begin req0 = 1'b1; data0 = oval; end
        raised = 1'b1;
      end
    end
    chk("done_latency", nd, W + 1);
    chk("shift_cycles", ns, W);
    chk("done_self", who == 0 ? done0 : done1, 1);
    chk("done_other", who == 0 ? done1 : done0, 0);
    chk("bcd_out", bcd_out, ref_bcd(val));
    chk("dp_data_zero", dpnz, 0);
    chk("stray_ack", stray, 0);
    $display("conv req%0d operand %0d -> bcd_out %h", who, val, bcd_out);
    tick();
    chk("busy_after", busy, 0);
    chk("done_cleared", done0 | done1, 0);
  endtask

  int            exp_tie[3];
  int            k, n, nd, w, lastc, sel;
  bit            both_ack, both_done, ro;
  logic [W-1:0]  v, ov, va, vb;

  initial begin
`ifdef BCD_ARB_ROUND_ROBIN_EN
    exp_tie = '{0, 1, 0};
`else
    exp_tie = '{0, 0, 0};
`endif
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    tick(); tick();
    chk("rst_ctrl", {ack0, ack1, done0, done1, busy, dp_load, dp_shift}, 0);
    chk("rst_bcd", bcd_out, 0);
    chk("rst_dp_data", dp_data, 0);
    rst = 1'b0;
    tick();

    conv(0, 36'd12345, 1'b0, '0);
    chk("bcd_12345", bcd_out, 44'h000_0001_2345);
    conv(1, 36'hF_FFFF_FFFF, 1'b0, '0);
    chk("bcd_max", bcd_out, 44'h687_1947_6735);
    conv(0, 36'd0, 1'b0, '0);

    // req0 dropped after ack, req1 raised mid-SHIFT and served only afterwards
    ov = rnd36();
    conv(0, rnd36(), 1'b1, ov);
    conv(1, ov, 1'b0, '0);

    for (int i = 0; i < 16; i++) begin
      w   = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 5));
      v   = (sel == 0) ? '0 : (sel == 1) ? '1 : rnd36();
      ro  = ($urandom_range(0, 3) == 0);
      ov  = rnd36();
      conv(w, v, ro, ov);
      if (ro) conv(1 - w, ov, 1'b0, '0);
    end

    // Simultaneous held requests
    rst = 1'b1; tick(); rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; data0 = 36'd1; data1 = 36'd2;
    k = 0; n = 0; lastc = 0; both_ack = 0; both_done = 0;
    while (k < 3 && n < 3 * (W + 3) + 10) begin
      tick();
      n++;
      if (ack0 && ack1) both_ack = 1'b1;
      if (done0 && done1) both_done = 1'b1;
      if (done0 || done1) begin
        w = done1 ? 1 : 0;
        chk("tie_winner", w, exp_tie[k]);
        chk("tie_bcd", bcd_out, (w == 1) ? 2 : 1);
        if (k > 0) chk("tie_spacing", cyc - lastc, W + 3);
        $display("tie done%0d bcd_out %h at cycle %0d", w, bcd_out, cyc);
        lastc = cyc;
        k++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("tie_count", k, 3);
    chk("ack_onehot", both_ack, 0);
    chk("done_onehot", both_done, 0);
    tick(); tick();

    // Reset in the 10th SHIFT cycle of a req0 conversion
    req0 = 1'b1; data0 = rnd36() | 36'd1;
    n = 0;
    while (!ack0 && n < 8) begin tick(); n++; end
    chk("rst_run_ack", ack0, 1);
    req0 = 1'b0;
    repeat (10) tick();
    chk("rst_run_shifting", dp_shift, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_bcd", bcd_out, 0);
    chk("midrst_shift", dp_shift, 0);
    nd = 0;
    repeat (W + 5) begin
      tick();
      if (done0 || done1) nd = 1;
    end
    chk("midrst_no_done", nd, 0);
    chk("midrst_bcd_hold", bcd_out, 0);
    $display("reset mid-SHIFT: busy %0b bcd_out %h", busy, bcd_out);

    va = rnd36(); vb = rnd36();
    req0 = 1'b1; req1 = 1'b1; data0 = va; data1 = vb;
    n = 0;
    while (!(ack0 || ack1) && n < 8) begin tick(); n++; end
    chk("post_rst_grant0", ack0, 1);
    chk("post_rst_grant1", ack1, 0);
    req0 = 1'b0; req1 = 1'b0;
    n = 0;
    while (!(done0 || done1) && n < W + 10) begin tick(); n++; end
    chk("post_rst_done0", done0, 1);
    chk("post_rst_bcd", bcd_out, ref_bcd(va));
    $display("post-reset grant done0 %0b bcd_out %h", done0, bcd_out);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
